bldc_commutation_ctrl: RTL and testbench
========================================

Name: bldc_commutation_ctrl

Overview:
- Sequences the three per-phase PWM high/low driver pairs of one brushless motor channel.
- Filters the hall sensor inputs and maps each hall sector to per-phase drive modes.
- Gates all duty and mode changes to PWM period boundaries so a driver never changes mid-period.
- Detects invalid hall codes and stalls, and latches a fault that forces every phase off.

Parameters:
- DUTY_W, `DUTY_CYCLE_WIDTH: duty command width; matches the driver duty_cycle input.
- HALL_FILT, 3: consecutive identical clock samples required to accept a new hall code (2..15).
- STALL_PERIODS, 1024: PWM periods with no accepted hall change, while running with duty>0, before a stall fault is raised.
- RAMP_STEP, 4: maximum duty change per period; used only when DUTY_RAMP_EN is defined.

Ports:
- clock  in  1  system clock; the same clock as the phase drivers.
- reset  in  1  synchronous, active-high.
- enable  in  1  run request; a low level clears a latched fault.
- direction  in  1  0=forward, 1=reverse.
- brake  in  1  short all low sides.
- duty_cmd  in  DUTY_W  requested duty.
- period_start  in  1  one-clock pulse when the PWM counter wraps to 0.
- hall  in  3  raw hall inputs {C,B,A}; asynchronous.
- phase_mode  out  6  2 bits per phase, {C,B,A}: 00=float, 01=PWM high, 10=low on, 11 never driven.
- duty_out  out  DUTY_W  duty applied to the PWM-high phase.
- sector  out  3  current sector 0..5; 7 when the hall code is invalid.
- fault  out  1  latched fault.

Behaviour:
- Reset values: phase_mode=0, duty_out=0, sector=7, fault=0. State=IDLE, filter and stall counters cleared.
- Hall input path:
  - Two-flop synchronizer, then the filter.
  - The filtered code updates once the synchronized code has been stable for HALL_FILT clocks.
  - Latency from hall edge to filtered code: 2+HALL_FILT clocks.
- Sector map:
  - Hall codes 101,100,110,010,011,001 map to sectors 0..5.
  - Codes 000 and 111 are invalid and set sector=7.
- Forward drive table (PWM phase / low phase), by sector: 0:A/B, 1:A/C, 2:B/C, 3:B/A, 4:C/A, 5:C/B. The third phase floats.
- Reverse drive: same table with the PWM and low roles swapped.
- All outputs are registered.
  - phase_mode and duty_out change only on the clock after period_start.
  - Exception: entering FAULT forces phase_mode=0 and duty_out=0 on the next clock, with no wait for period_start.
- Commutation blanking:
  - If the target mode differs from the current mode at a period_start, only phases whose mode is unchanged keep driving.
  - Changed phases are driven 00 for that period.
  - Their new mode is applied at the following period_start.
- States:
  - IDLE: outputs off. Go to RUN when enable=1, fault=0 and the filtered code is valid.
  - RUN: apply the table. Go to BRAKE when brake=1. Go to IDLE when enable=0.
  - BRAKE: phase_mode=101010, duty_out=0, applied at period_start. Return to RUN when brake=0.
  - FAULT: fault=1, outputs off. Go to IDLE only when enable=0.
- Fault sources:
  - An invalid filtered code in RUN or BRAKE.
  - The stall counter reaching STALL_PERIODS.
- Stall counter:
  - Counts period_start pulses in RUN while duty_out>0.
  - Cleared by any accepted sector change, by leaving RUN, and while duty_out=0.
  - Saturates and does not wrap.
- Duty: duty_out = duty_cmd, sampled at period_start in RUN.
- Simultaneous events, priority order: reset > fault > enable=0 > brake > commutation.
- A reset mid-period returns all outputs to their reset values on the next clock.

Optional Feature:
- Macro: DUTY_RAMP_EN.
- Defined: at each period_start in RUN, duty_out moves toward duty_cmd by at most RAMP_STEP. Arithmetic is unsigned with no overshoot, and duty_out clamps exactly to duty_cmd. Entering BRAKE, IDLE or FAULT sets duty_out=0 immediately.
- Undefined: duty_out tracks duty_cmd directly at each period_start.

Decomposition:
- phase_driver.vh holds `DUTY_CYCLE_WIDTH, the phase mode encodings (MODE_FLOAT, MODE_PWM, MODE_LOW), the state encodings and the INVALID_SECTOR value.
- Sub-module hall_filter: synchronizer, stability counter, filtered code, and a one-clock change-pulse output.

Test Plan:
- Reset, then enable=1, hall=101, duty_cmd=200, period pulses every 1000 clocks -> after the second period_start: phase_mode=A01 B10 C00, duty_out=200, sector=0.
- In RUN, step hall 101->100 -> at the next period_start B is 00 and C is 00, with A unchanged at 01 for one period. At the following period_start C=10.
- direction=1 with hall=110 (sector 2) -> phase_mode shows C=01 and B=10; duty_out equals duty_cmd.
- hall=111 for at least 2+HALL_FILT clocks while in RUN -> one clock later fault=1 and phase_mode=0. Then enable=0 -> fault=0 and state IDLE.
- Hold hall fixed with duty_cmd=50 for 1024 periods -> fault rises at the 1024th period_start. Repeat with duty_cmd=0 -> no fault.
- brake=1 asserted mid-period -> phase_mode=101010 only after the next period_start. With DUTY_RAMP_EN, a duty_cmd step 0->20 and RAMP_STEP=4 gives duty_out 4, 8, 12, 16, 20 over 5 periods.

Source files
------------

// File: rtl/bldc_commutation_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bldc_commutation_ctrl_pkg
// Shared definitions for the BLDC commutation controller:
//   - DUTY_CYCLE_WIDTH macro (driver duty width, defaults to 8)
//   - phase mode encodings (MODE_FLOAT / MODE_PWM / MODE_LOW)
//   - controller state encoding
//   - INVALID_SECTOR value
//   - hall-code -> sector map and sector -> drive-mode table
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef DUTY_CYCLE_WIDTH
`define DUTY_CYCLE_WIDTH 8
`endif

package bldc_commutation_ctrl_pkg;

  localparam int DUTY_W_DEF = `DUTY_CYCLE_WIDTH;
  localparam int HALL_W     = 3;

  // Per-phase drive mode, 2 bits each; 2'b11 is never driven.
  localparam logic [1:0] MODE_FLOAT = 2'b00;
  localparam logic [1:0] MODE_PWM   = 2'b01;
  localparam logic [1:0] MODE_LOW   = 2'b10;

  // All low sides on, packed {C,B,A}.
  localparam logic [5:0] BRAKE_MODES = {MODE_LOW, MODE_LOW, MODE_LOW};

  localparam logic [2:0] INVALID_SECTOR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Hall code {C,B,A} -> sector 0..5; 000 and 111 are impossible codes.
  function automatic logic [2:0] hall_to_sector(input logic [2:0] hall);
    logic [2:0] sector;
    case (hall)
      3'b101:  sector = 3'd0;
      3'b100:  sector = 3'd1;
      3'b110:  sector = 3'd2;
      3'b010:  sector = 3'd3;
      3'b011:  sector = 3'd4;
      3'b001:  sector = 3'd5;
      default: sector = INVALID_SECTOR;
    endcase
    return sector;
  endfunction

  // Sector -> packed {C,B,A} modes. Phase index 0=A, 1=B, 2=C.
  // Reverse rotation swaps the PWM and low roles of the two driven phases.
  function automatic logic [5:0] drive_modes(input logic [2:0] sector,
                                             input logic       reverse);
    logic [1:0] pwm_ph;
    logic [1:0] low_ph;
    logic [1:0] tmp;
    logic [5:0] modes;
    logic       ok;
    pwm_ph = 2'd0;
    low_ph = 2'd0;
    modes  = '0;
    ok     = 1'b1;
    case (sector)
      3'd0:    begin pwm_ph = 2'd0; low_ph = 2'd1; end
      3'd1:    begin pwm_ph = 2'd0; low_ph = 2'd2; end
      3'd2:    begin pwm_ph = 2'd1; low_ph = 2'd2; end
      3'd3:    begin pwm_ph = 2'd1; low_ph = 2'd0; end
      3'd4:    begin pwm_ph = 2'd2; low_ph = 2'd0; end
      3'd5:    begin pwm_ph = 2'd2; low_ph = 2'd1; end
      default: ok = 1'b0;
    endcase
    if (reverse) begin
      tmp    = pwm_ph;
      pwm_ph = low_ph;
      low_ph = tmp;
    end
    if (ok) begin
      modes[{pwm_ph, 1'b0} +: 2] = MODE_PWM;
      modes[{low_ph, 1'b0} +: 2] = MODE_LOW;
    end
    return modes;
  endfunction

endpackage

// File: rtl/bldc_commutation_ctrl_if.sv
// -----------------------------------------------------------------------------
// bldc_commutation_ctrl_if
// Control/status bundle between the commutation controller and its user.
//   i_enable       run request; low clears a latched fault
//   i_direction    0 = forward, 1 = reverse
//   i_brake        short all low sides
//   i_duty_cmd     requested duty
//   i_period_start one-clock pulse when the PWM counter wraps to 0
//   i_hall         raw hall inputs {C,B,A}, asynchronous
//   o_phase_mode   2 bits per phase {C,B,A}
//   o_duty_out     duty applied to the PWM-high phase
//   o_sector       current sector 0..5, 7 when invalid
//   o_fault        latched fault
// Modports: master (drives i_*), slave (the controller).
// -----------------------------------------------------------------------------
interface bldc_commutation_ctrl_if #(
  parameter int DUTY_W = bldc_commutation_ctrl_pkg::DUTY_W_DEF
);
  logic              i_enable;
  logic              i_direction;
  logic              i_brake;
  logic [DUTY_W-1:0] i_duty_cmd;
  logic              i_period_start;
  logic [2:0]        i_hall;
  logic [5:0]        o_phase_mode;
  logic [DUTY_W-1:0] o_duty_out;
  logic [2:0]        o_sector;
  logic              o_fault;

  modport master (
    output i_enable, i_direction, i_brake, i_duty_cmd, i_period_start, i_hall,
    input  o_phase_mode, o_duty_out, o_sector, o_fault
  );

  modport slave (
    input  i_enable, i_direction, i_brake, i_duty_cmd, i_period_start, i_hall,
    output o_phase_mode, o_duty_out, o_sector, o_fault
  );
endinterface

// File: rtl/bldc_commutation_ctrl_hall_filter.sv
// -----------------------------------------------------------------------------
// hall_filter
// Two-flop synchronizer plus stability filter for the raw hall inputs.
// A new code is accepted once the synchronized value has been seen on
// HALL_FILT consecutive clocks; hall edge to o_code latency is 2+HALL_FILT.
//   i_clock   system clock
//   i_reset   synchronous, active-high
//   i_hall    raw hall inputs {C,B,A}
//   o_code    filtered hall code (000 after reset)
//   o_change  one-clock pulse, aligned with o_code, when an accepted code differs
// -----------------------------------------------------------------------------
module hall_filter
  import bldc_commutation_ctrl_pkg::*;
#(
  parameter int HALL_FILT = 3
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [HALL_W-1:0] i_hall,
  output logic [HALL_W-1:0] o_code,
  output logic              o_change
);

  // Count value on which the HALL_FILT-th identical sample is seen.
  localparam logic [3:0] FILT_LAST = 4'(HALL_FILT - 1);

  logic [HALL_W-1:0] r_sync1;
  logic [HALL_W-1:0] r_sync2;
  logic [HALL_W-1:0] r_cand;
  logic [HALL_W-1:0] r_code;
  logic [3:0]        r_cnt;
  logic              r_change;

  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would collapse the synchronizer.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_code   <= '0;
      r_cnt    <= '0;
      r_change <= 1'b0;
    end else begin
      r_sync1  <= i_hall;
      r_sync2  <= r_sync1;
      r_change <= 1'b0;
      if (r_sync2 != r_cand) begin
        // First sample of a new candidate restarts the stability count.
        r_cand <= r_sync2;
        r_cnt  <= 4'd1;
      end else if (r_cnt != FILT_LAST) begin
        r_cnt <= r_cnt + 4'd1;
      end else if (r_cand != r_code) begin
        r_code   <= r_cand;
        r_change <= 1'b1;
      end
    end
  end

  assign o_code   = r_code;
  assign o_change = r_change;

endmodule

// File: rtl/bldc_commutation_ctrl.sv
// -----------------------------------------------------------------------------
// bldc_commutation_ctrl
// Commutation sequencer for one BLDC channel: filters the hall sensors, maps
// the sector to per-phase drive modes, gates mode/duty changes to PWM period
// boundaries with one blanking period on commutation, and latches invalid-hall
// and stall faults that force every phase off.
//   i_clock  system clock (shared with the phase drivers)
//   i_reset  synchronous, active-high
//   bus      bldc_commutation_ctrl_if.slave (enable, direction, brake,
//            duty_cmd, period_start, hall in; phase_mode, duty_out, sector,
//            fault out)
// Optional feature macro: DUTY_RAMP_EN -- when defined, duty_out slews toward
// duty_cmd by at most RAMP_STEP per period and drops to 0 immediately when
// leaving RUN; when undefined, duty_out takes duty_cmd at each period start.
// -----------------------------------------------------------------------------
module bldc_commutation_ctrl
  import bldc_commutation_ctrl_pkg::*;
#(
  parameter int DUTY_W        = DUTY_W_DEF,
  parameter int HALL_FILT     = 3,
  parameter int STALL_PERIODS = 1024
`ifdef DUTY_RAMP_EN
  , parameter int RAMP_STEP   = 4
`endif
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  bldc_commutation_ctrl_if.slave  bus
);

  localparam int              STALL_W   = $clog2(STALL_PERIODS + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_PERIODS);

  logic [2:0]         w_filt_code;
  logic               w_hall_change;
  logic [2:0]         w_sector;
  logic               w_code_valid;
  logic [5:0]         w_target;
  logic [5:0]         w_blank_mode;
  logic               w_blank_next;
  logic [DUTY_W-1:0]  w_duty_run;
  logic [STALL_W-1:0] w_stall_next;
  logic               w_stall_fault;
  state_e             w_state_next;

  state_e             r_state;
  logic [5:0]         r_mode;
  logic [DUTY_W-1:0]  r_duty;
  logic [2:0]         r_sector;
  logic               r_fault;
  logic               r_blank;
  logic [STALL_W-1:0] r_stall;

  hall_filter #(
    .HALL_FILT (HALL_FILT)
  ) u_hall_filter (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_hall   (bus.i_hall),
    .o_code   (w_filt_code),
    .o_change (w_hall_change)
  );

  assign w_sector     = hall_to_sector(w_filt_code);
  assign w_code_valid = (w_sector != INVALID_SECTOR);
  assign w_target     = drive_modes(w_sector, bus.i_direction);

  // Commutation blanking: a phase whose mode must change is floated for one
  // period first. r_blank marks that the current period is such a blanking
  // period, so floated phases may now take their target mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_blank_mode = '0;
    for (int p = 0; p < 3; p++) begin
      if (r_mode[2*p +: 2] == w_target[2*p +: 2]) begin
        w_blank_mode[2*p +: 2] = r_mode[2*p +: 2];
      end else if (r_blank && (r_mode[2*p +: 2] == MODE_FLOAT)) begin
        w_blank_mode[2*p +: 2] = w_target[2*p +: 2];
      end else begin
        w_blank_mode[2*p +: 2] = MODE_FLOAT;
      end
    end
    w_blank_next = (w_blank_mode != w_target);
  end

`ifdef DUTY_RAMP_EN
  localparam logic [DUTY_W-1:0] RAMP_V = DUTY_W'(RAMP_STEP);

  // Unsigned slew toward the command; the final step lands exactly on it.
  always_comb begin
    w_duty_run = bus.i_duty_cmd;
    if (bus.i_duty_cmd > r_duty) begin
      if ((bus.i_duty_cmd - r_duty) > RAMP_V) w_duty_run = r_duty + RAMP_V;
    end else if ((r_duty - bus.i_duty_cmd) > RAMP_V) begin
      w_duty_run = r_duty - RAMP_V;
    end
  end
`else
  always_comb begin
    w_duty_run = bus.i_duty_cmd;
  end
`endif

  // Stall counter: periods spent in RUN with nonzero duty and no accepted
  // hall change. Saturates at STALL_MAX.
  always_comb begin
    w_stall_next = r_stall;
    if ((r_state != ST_RUN) || w_hall_change || (r_duty == '0)) begin
      w_stall_next = '0;
    end else if (bus.i_period_start && (r_stall != STALL_MAX)) begin
      w_stall_next = r_stall + 1'b1;
    end
    w_stall_fault = (r_state == ST_RUN) && (w_stall_next == STALL_MAX);
  end

  // Next state; branch order encodes fault > enable=0 > brake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_enable && w_code_valid) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!w_code_valid || w_stall_fault) w_state_next = ST_FAULT;
        else if (!bus.i_enable)             w_state_next = ST_IDLE;
        else if (bus.i_brake)               w_state_next = ST_BRAKE;
      end
      ST_BRAKE: begin
        if (!w_code_valid)      w_state_next = ST_FAULT;
        else if (!bus.i_enable) w_state_next = ST_IDLE;
        else if (!bus.i_brake)  w_state_next = ST_RUN;
      end
      ST_FAULT: begin
        if (!bus.i_enable) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Output registers. Drive changes land on the clock after period_start,
  // except a fault, which kills the drive on the very next clock.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mode   <= '0;
      r_duty   <= '0;
      r_sector <= INVALID_SECTOR;
      r_fault  <= 1'b0;
      r_blank  <= 1'b0;
      r_stall  <= '0;
    end else begin
      r_sector <= w_sector;
      r_fault  <= (w_state_next == ST_FAULT);
      r_stall  <= w_stall_next;
      if (w_state_next == ST_FAULT) begin
        r_mode  <= '0;
        r_duty  <= '0;
        r_blank <= 1'b0;
      end else if (bus.i_period_start) begin
        case (w_state_next)
          ST_RUN: begin
            r_mode  <= w_blank_mode;
            r_blank <= w_blank_next;
            r_duty  <= w_duty_run;
          end
          ST_BRAKE: begin
            r_mode  <= BRAKE_MODES;
            r_blank <= 1'b0;
            r_duty  <= '0;
          end
          default: begin
            r_mode  <= '0;
            r_blank <= 1'b0;
            r_duty  <= '0;
          end
        endcase
      end
`ifdef DUTY_RAMP_EN
      else if (w_state_next != ST_RUN) begin
        r_duty <= '0;
      end
`endif
    end
  end

  assign bus.o_phase_mode = r_mode;
  assign bus.o_duty_out   = r_duty;
  assign bus.o_sector     = r_sector;
  assign bus.o_fault      = r_fault;

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bldc_commutation_ctrl
// Directed bench for bldc_commutation_ctrl. Inputs are driven and outputs
// sampled on the falling clock edge; period_start is pulsed by the bench.
// Mode constants are packed {C,B,A}, 2 bits per phase.
// -----------------------------------------------------------------------------
module tb_bldc_commutation_ctrl;

  localparam int DUTY_W = 8;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  bldc_commutation_ctrl_if #(.DUTY_W(DUTY_W)) bus ();

  bldc_commutation_ctrl #(
    .DUTY_W        (DUTY_W),
    .HALL_FILT     (3),
    .STALL_PERIODS (1024)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-clock period_start; returns on the falling edge after the pulse edge.
  task automatic pulse();
    bus.i_period_start = 1'b1;
    @(negedge clk);
    bus.i_period_start = 1'b0;
  endtask

  initial begin
    int exp_duty;
    rst                = 1'b1;
    bus.i_enable       = 1'b0;
    bus.i_direction    = 1'b0;
    bus.i_brake        = 1'b0;
    bus.i_duty_cmd     = '0;
    bus.i_period_start = 1'b0;
    bus.i_hall         = 3'b101;
    clocks(3);

    check("rst_mode",   bus.o_phase_mode, 6'b000000);
    check("rst_duty",   bus.o_duty_out,   8'd0);
    check("rst_sector", bus.o_sector,     3'd7);
    check("rst_fault",  bus.o_fault,      1'b0);

    // Start-up, sector 0 forward, 1000-clock periods.
    rst            = 1'b0;
    bus.i_enable   = 1'b1;
    bus.i_duty_cmd = 8'd200;
    clocks(999);
    pulse();
    check("start_blank_mode", bus.o_phase_mode, 6'b000000);
    check("start_duty",       bus.o_duty_out,   8'd200);
    clocks(999);
    pulse();
    check("s0_mode",   bus.o_phase_mode, 6'b00_10_01);
    check("s0_duty",   bus.o_duty_out,   8'd200);
    check("s0_sector", bus.o_sector,     3'd0);

    // Commutate 101 -> 100 (sector 1: A pwm, C low), 20-clock periods.
    bus.i_hall = 3'b100;
    clocks(10);
    check("s1_sector", bus.o_sector, 3'd1);
    clocks(8);
    pulse();
    check("s1_blank_mode", bus.o_phase_mode, 6'b00_00_01);
    clocks(19);
    pulse();
    check("s1_mode", bus.o_phase_mode, 6'b10_00_01);

    // Reverse, hall 110 (sector 2): C pwm, B low; every phase changes.
    bus.i_direction = 1'b1;
    bus.i_hall      = 3'b110;
    clocks(10);
    check("s2_sector", bus.o_sector, 3'd2);
    clocks(8);
    pulse();
    check("rev_blank_mode", bus.o_phase_mode, 6'b00_00_00);
    bus.i_duty_cmd = 8'd77;
    clocks(19);
    pulse();
    check("rev_mode", bus.o_phase_mode, 6'b01_10_00);
    check("rev_duty", bus.o_duty_out,   8'd77);
    bus.i_duty_cmd = 8'd90;
    clocks(5);
    check("duty_hold_mid_period", bus.o_duty_out, 8'd77);

    // Brake mid-period: nothing changes until the next period_start.
    bus.i_brake = 1'b1;
    clocks(5);
    check("brake_wait_mode", bus.o_phase_mode, 6'b01_10_00);
    clocks(9);
    pulse();
    check("brake_mode", bus.o_phase_mode, 6'b10_10_10);
    check("brake_duty", bus.o_duty_out,   8'd0);
    // Release: B stays low, A and C float for one period.
    bus.i_brake = 1'b0;
    clocks(19);
    pulse();
    check("unbrake_blank_mode", bus.o_phase_mode, 6'b00_10_00);
    check("unbrake_duty",       bus.o_duty_out,   8'd90);
    clocks(19);
    pulse();
    check("unbrake_mode", bus.o_phase_mode, 6'b01_10_00);

    // Two-sample glitch to 111 is shorter than the filter and is ignored.
    bus.i_hall = 3'b111;
    clocks(2);
    bus.i_hall = 3'b110;
    clocks(10);
    check("glitch_fault",  bus.o_fault,  1'b0);
    check("glitch_sector", bus.o_sector, 3'd2);

    // Invalid code held: accepted after 2+3 clocks, fault on the clock after.
    bus.i_hall = 3'b111;
    clocks(5);
    check("inval_fault_early", bus.o_fault, 1'b0);
    clocks(1);
    check("inval_fault",  bus.o_fault,      1'b1);
    check("inval_mode",   bus.o_phase_mode, 6'b000000);
    check("inval_duty",   bus.o_duty_out,   8'd0);
    check("inval_sector", bus.o_sector,     3'd7);
    bus.i_hall = 3'b101;
    clocks(10);
    check("fault_latched", bus.o_fault, 1'b1);
    bus.i_enable = 1'b0;
    clocks(1);
    check("fault_cleared", bus.o_fault, 1'b0);

    // Stall: hall fixed, duty 50, 10-clock periods. The first pulse loads the
    // duty; the 1024th pulse seen with duty_out=50 raises the fault.
    bus.i_direction = 1'b0;
    bus.i_duty_cmd  = 8'd50;
    bus.i_enable    = 1'b1;
    clocks(2);
    pulse();
    repeat (1023) begin
      clocks(9);
      pulse();
    end
    check("stall_fault_before", bus.o_fault,    1'b0);
    check("stall_duty",         bus.o_duty_out, 8'd50);
    clocks(9);
    pulse();
    check("stall_fault", bus.o_fault, 1'b1);

    // Same with duty 0: the counter never advances.
    bus.i_enable = 1'b0;
    clocks(1);
    bus.i_duty_cmd = 8'd0;
    bus.i_enable   = 1'b1;
    clocks(2);
    repeat (1030) begin
      pulse();
      clocks(9);
    end
    check("nostall_fault", bus.o_fault,      1'b0);
    check("nostall_mode",  bus.o_phase_mode, 6'b00_10_01);

    // Duty step 0 -> 20.
    bus.i_duty_cmd = 8'd20;
    for (int i = 1; i <= 5; i++) begin
      pulse();
`ifdef DUTY_RAMP_EN
      exp_duty = 4 * i;
`else
      exp_duty = 20;
`endif
      check($sformatf("step_duty_%0d", i), bus.o_duty_out, exp_duty);
      clocks(9);
    end

    // Reset mid-period restores reset values on the next clock.
    clocks(4);
    rst = 1'b1;
    clocks(1);
    check("midrst_mode",   bus.o_phase_mode, 6'b000000);
    check("midrst_duty",   bus.o_duty_out,   8'd0);
    check("midrst_sector", bus.o_sector,     3'd7);
    check("midrst_fault",  bus.o_fault,      1'b0);
    rst = 1'b0;

    // Run again, then drop enable and raise brake together: IDLE wins.
    clocks(8);
    pulse();
    clocks(9);
    pulse();
    check("rerun_mode", bus.o_phase_mode, 6'b00_10_01);
    bus.i_enable = 1'b0;
    bus.i_brake  = 1'b1;
    clocks(3);
    pulse();
    check("prio_idle_mode", bus.o_phase_mode, 6'b000000);
    check("prio_idle_duty", bus.o_duty_out,   8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
